alu_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared 8-bit combinational ALU. Two requesters, such as the execute stage and a background address/checksum unit, submit operand/opcode transactions over valid/ready handshakes. The block grants the requesters round-robin, drives the ALU's `SrcA`/`SrcB`/`ALUControl` inputs from registered operands, and captures `ALUResult`/`Zero`. It then returns the result to the granted requester through a response handshake.

---
 rtl/alu_arbiter.sv | 167 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Round-robin two-port arbiter and sequencer for a shared
//                combinational ALU. Accepts one operand/opcode transaction
//                at a time, drives the ALU from registered operands for one
//                EXEC cycle, captures the result and returns it over a
//                per-port response handshake.
//  Options     : define ALU_ARB_STATS_EN to build the saturating per-port
//                grant counters (GntCnt0/GntCnt1); otherwise they read 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ReqValid0,
  input  logic             ReqValid1,
  output logic             ReqReady0,
  output logic             ReqReady1,
  input  logic [WIDTH-1:0] ReqA0,
  input  logic [WIDTH-1:0] ReqA1,
  input  logic [WIDTH-1:0] ReqB0,
  input  logic [WIDTH-1:0] ReqB1,
  input  logic [1:0]       ReqOp0,
  input  logic [1:0]       ReqOp1,
  output logic             RspValid0,
  output logic             RspValid1,
  input  logic             RspReady0,
  input  logic             RspReady1,
  output logic [WIDTH-1:0] RspResult,
  output logic             RspZero,
  output logic             Busy,
  output logic [WIDTH-1:0] SrcA,
  output logic [WIDTH-1:0] SrcB,
  output logic [1:0]       ALUControl,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic             Zero,
  output logic [7:0]       GntCnt0,
  output logic [7:0]       GntCnt1
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic             ptr_q;      // priority port when both request
  logic             gnt_q;      // port being served
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             rsp_v0_q;
  logic             rsp_v1_q;
  logic             busy_q;

  logic             in_idle;
  logic             rdy0;
  logic             rdy1;
  logic             accept;
  logic             rsp_done;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;
  logic [1:0]       op_d;

  // A port wins if it is the only requester, or if both request and the
  // pointer names it. Held off during reset so nothing is accepted then.
  assign in_idle  = (state_q == S_IDLE);
  assign rdy0     = ~reset & in_idle & ReqValid0 & ~(ReqValid1 & ptr_q);
  assign rdy1     = ~reset & in_idle & ReqValid1 & ~(ReqValid0 & ~ptr_q);
  assign accept   = rdy0 | rdy1;
  assign rsp_done = (rsp_v0_q & RspReady0) | (rsp_v1_q & RspReady1);

  assign a_d  = rdy1 ? ReqA1  : ReqA0;
  assign b_d  = rdy1 ? ReqB1  : ReqB0;
  assign op_d = rdy1 ? ReqOp1 : ReqOp0;

  assign ReqReady0  = rdy0;
  assign ReqReady1  = rdy1;
  assign RspValid0  = rsp_v0_q;
  assign RspValid1  = rsp_v1_q;
  assign RspResult  = res_q;
  assign RspZero    = zero_q;
  assign Busy       = busy_q;
  assign SrcA       = a_q;
  assign SrcB       = b_q;
  assign ALUControl = op_q;

  // Sequencer: accept -> one ALU cycle -> hold response until consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= 1'b0;
      gnt_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 2'b00;
      res_q    <= '0;
      zero_q   <= 1'b0;
      rsp_v0_q <= 1'b0;
      rsp_v1_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            gnt_q   <= rdy1;
            busy_q  <= 1'b1;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_q    <= ALUResult;
          zero_q   <= Zero;
          rsp_v0_q <= ~gnt_q;
          rsp_v1_q <= gnt_q;
          state_q  <= S_RESP;
        end
        S_RESP: begin
          // Only the granted port's ready matters; rsp_v*_q already masks it.
          if (rsp_done) begin
            rsp_v0_q <= 1'b0;
            rsp_v1_q <= 1'b0;
            ptr_q    <= ~gnt_q;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [7:0] cnt0_q;
  logic [7:0] cnt1_q;

  // Saturating count of accepted requests per port.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= 8'h00;
      cnt1_q <= 8'h00;
    end else begin
      if (rdy0 && (cnt0_q != 8'hFF)) cnt0_q <= cnt0_q + 8'd1;
      if (rdy1 && (cnt1_q != 8'hFF)) cnt1_q <= cnt1_q + 8'd1;
    end
  end

  assign GntCnt0 = cnt0_q;
  assign GntCnt1 = cnt1_q;
`else
  assign GntCnt0 = 8'h00;
  assign GntCnt1 = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter with a behavioural
//                ALU and an arbitration/result reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  logic       clk;
  logic       reset;
  logic       ReqValid0, ReqValid1;
  logic       ReqReady0, ReqReady1;
  logic [7:0] ReqA0, ReqA1, ReqB0, ReqB1;
  logic [1:0] ReqOp0, ReqOp1;
  logic       RspValid0, RspValid1;
  logic       RspReady0, RspReady1;
  logic [7:0] RspResult;
  logic       RspZero;
  logic       Busy;
  logic [7:0] SrcA, SrcB;
  logic [1:0] ALUControl;
  logic [7:0] ALUResult;
  logic       Zero;
  logic [7:0] GntCnt0, GntCnt1;

  int compared   = 0;
  int mismatched = 0;
  int exp_ptr    = 0;
  int exp_cnt0   = 0;
  int exp_cnt1   = 0;

  alu_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .ReqValid0(ReqValid0), .ReqValid1(ReqValid1),
    .ReqReady0(ReqReady0), .ReqReady1(ReqReady1),
    .ReqA0(ReqA0), .ReqA1(ReqA1), .ReqB0(ReqB0), .ReqB1(ReqB1),
    .ReqOp0(ReqOp0), .ReqOp1(ReqOp1),
    .RspValid0(RspValid0), .RspValid1(RspValid1),
    .RspReady0(RspReady0), .RspReady1(RspReady1),
    .RspResult(RspResult), .RspZero(RspZero), .Busy(Busy),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
    .ALUResult(ALUResult), .Zero(Zero),
    .GntCnt0(GntCnt0), .GntCnt1(GntCnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plain arithmetic definition of the four ALU operations, modulo 256.
  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] op);
    int r;
    case (op)
      2'b00:   r = int'(a & b);
      2'b01:   r = int'(a | b);
      2'b10:   r = int'(a) + int'(b);
      default: r = int'(a) - int'(b) + 256;
    endcase
    return 8'(r % 256);
  endfunction

  // Combinational ALU attached to the arbiter.
  always_comb begin
    ALUResult = ref_alu(SrcA, SrcB, ALUControl);
    Zero      = (ref_alu(SrcA, SrcB, ALUControl) == 8'h00);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_counts();
`ifdef ALU_ARB_STATS_EN
    chk("gntcnt0", 32'(GntCnt0), 32'(exp_cnt0));
    chk("gntcnt1", 32'(GntCnt1), 32'(exp_cnt1));
`else
    chk("gntcnt0", 32'(GntCnt0), 32'd0);
    chk("gntcnt1", 32'(GntCnt1), 32'd0);
`endif
  endtask

  // One full transaction starting and ending at a falling edge. The losing
  // port (if any) stays valid afterwards; bp = cycles of response stall,
  // during which the non-granted port's RspReady is held high.
  task automatic serve(input bit v0, input bit v1,
                       input logic [7:0] a0, input logic [7:0] b0, input logic [1:0] op0,
                       input logic [7:0] a1, input logic [7:0] b1, input logic [1:0] op1,
                       input int bp);
    int         w;
    logic [7:0] ea, eb, er;
    logic [1:0] eo;
    w  = (v0 && v1) ? exp_ptr : (v1 ? 1 : 0);
    ea = (w == 1) ? a1 : a0;
    eb = (w == 1) ? b1 : b0;
    eo = (w == 1) ? op1 : op0;
    er = ref_alu(ea, eb, eo);

    ReqValid0 = v0; ReqValid1 = v1;
    ReqA0 = a0; ReqB0 = b0; ReqOp0 = op0;
    ReqA1 = a1; ReqB1 = b1; ReqOp1 = op1;
    RspReady0 = 1'b0; RspReady1 = 1'b0;
    #1;
    chk("idle_ready0", 32'(ReqReady0), 32'(w == 0));
    chk("idle_ready1", 32'(ReqReady1), 32'(w == 1));
    chk("idle_busy", 32'(Busy), 32'd0);

    @(posedge clk);
    @(negedge clk);
    if (w == 0) begin
      ReqValid0 = 1'b0;
      if (exp_cnt0 < 255) exp_cnt0++;
    end else begin
      ReqValid1 = 1'b0;
      if (exp_cnt1 < 255) exp_cnt1++;
    end
    #1;
    chk("exec_busy", 32'(Busy), 32'd1);
    chk("exec_ready", 32'({ReqReady1, ReqReady0}), 32'd0);
    chk("exec_rspvalid", 32'({RspValid1, RspValid0}), 32'd0);
    chk("exec_srca", 32'(SrcA), 32'(ea));
    chk("exec_srcb", 32'(SrcB), 32'(eb));
    chk("exec_aluctl", 32'(ALUControl), 32'(eo));

    @(negedge clk);
    for (int i = 0; i <= bp; i++) begin
      if (i == bp) begin
        RspReady0 = (w == 0); RspReady1 = (w == 1);
      end else begin
        RspReady0 = (w == 1); RspReady1 = (w == 0);
      end
      #1;
      chk("resp_valid", 32'({RspValid1, RspValid0}), (w == 1) ? 32'd2 : 32'd1);
      chk("resp_result", 32'(RspResult), 32'(er));
      chk("resp_zero", 32'(RspZero), 32'(er == 8'h00));
      chk("resp_busy", 32'(Busy), 32'd1);
      chk("resp_ready", 32'({ReqReady1, ReqReady0}), 32'd0);
      @(negedge clk);
    end
    RspReady0 = 1'b0; RspReady1 = 1'b0;
    exp_ptr = 1 - w;
    #1;
    chk("done_rspvalid", 32'({RspValid1, RspValid0}), 32'd0);
    chk("done_busy", 32'(Busy), 32'd0);
    chk_counts();
  endtask

  initial begin
    logic [7:0] ra0, rb0, ra1, rb1;
    logic [1:0] ro0, ro1;
    int         rv;

    // Reset with both ports requesting: nothing may be accepted.
    reset = 1'b1;
    ReqValid0 = 1'b1; ReqValid1 = 1'b1;
    ReqA0 = 8'h11; ReqB0 = 8'h22; ReqOp0 = 2'b10;
    ReqA1 = 8'h33; ReqB1 = 8'h44; ReqOp1 = 2'b11;
    RspReady0 = 1'b0; RspReady1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'({ReqReady1, ReqReady0}), 32'd0);
    chk("rst_rspvalid", 32'({RspValid1, RspValid0}), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_srca", 32'(SrcA), 32'd0);
    chk("rst_srcb", 32'(SrcB), 32'd0);
    chk("rst_aluctl", 32'(ALUControl), 32'd0);
    chk("rst_result", 32'(RspResult), 32'd0);
    chk("rst_zero", 32'(RspZero), 32'd0);
    chk_counts();
    ReqValid0 = 1'b0; ReqValid1 = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // Simultaneous requests: port 0 SUB first, then port 1 AND.
    serve(1, 1, 8'h30, 8'h10, 2'b11, 8'hFF, 8'h0F, 2'b00, 0);
    serve(0, 1, 8'h00, 8'h00, 2'b00, 8'hFF, 8'h0F, 2'b00, 0);

    // Single request on port 0: ADD 0x10 + 0x20.
    serve(1, 0, 8'h10, 8'h20, 2'b10, 8'h00, 8'h00, 2'b00, 0);

    // Fairness: both ports continuously valid for 8 transactions.
    for (int i = 0; i < 8; i++) begin
      serve(1, 1, 8'($urandom), 8'($urandom), 2'($urandom),
                  8'($urandom), 8'($urandom), 2'($urandom), 0);
    end

    // Backpressure on port 1 for 5 cycles: OR 0xF0 | 0x0F.
    serve(0, 1, 8'h00, 8'h00, 2'b00, 8'hF0, 8'h0F, 2'b01, 5);

    // Zero and wrap cases.
    serve(1, 0, 8'h42, 8'h42, 2'b11, 8'h00, 8'h00, 2'b00, 0);
    serve(0, 1, 8'h00, 8'h00, 2'b00, 8'hFF, 8'h01, 2'b10, 0);
    serve(1, 0, 8'h00, 8'h01, 2'b11, 8'h00, 8'h00, 2'b00, 1);

    // Random mix of request patterns, payloads and stalls.
    for (int i = 0; i < 30; i++) begin
      rv  = int'($urandom_range(1, 3));
      ra0 = 8'($urandom); rb0 = 8'($urandom); ro0 = 2'($urandom);
      ra1 = 8'($urandom); rb1 = 8'($urandom); ro1 = 2'($urandom);
      serve(rv[0], rv[1], ra0, rb0, ro0, ra1, rb1, ro1, int'($urandom_range(0, 3)));
    end
    ReqValid0 = 1'b0; ReqValid1 = 1'b0;
    @(negedge clk);

    // Leave the pointer at port 1, then reset in the middle of EXEC.
    serve(1, 0, 8'h05, 8'h06, 2'b10, 8'h00, 8'h00, 2'b00, 0);
    ReqValid0 = 1'b1; ReqA0 = 8'h07; ReqB0 = 8'h01; ReqOp0 = 2'b10;
    #1;
    chk("mid_ready0", 32'(ReqReady0), 32'd1);
    @(posedge clk);
    @(negedge clk);
    ReqValid0 = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_ptr = 0; exp_cnt0 = 0; exp_cnt1 = 0;
    #1;
    chk("mid_busy", 32'(Busy), 32'd0);
    chk("mid_srca", 32'(SrcA), 32'd0);
    chk("mid_result", 32'(RspResult), 32'd0);
    chk_counts();
    for (int i = 0; i < 4; i++) begin
      chk("mid_no_rsp", 32'({RspValid1, RspValid0}), 32'd0);
      @(negedge clk);
    end
    // Pointer back at 0: port 0 wins a simultaneous request.
    serve(1, 1, 8'h09, 8'h03, 2'b11, 8'hAA, 8'h55, 2'b01, 0);
    serve(0, 1, 8'h00, 8'h00, 2'b00, 8'hAA, 8'h55, 2'b01, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
